// File: rtl/bus_region_decoder.sv
// bus_region_decoder
//   Registered base/mask address decoder for the 6809 bus. A bus cycle is
//   decoded once, when it starts. The winning region's chip enable is then
//   held until the CPU ends the cycle. Regions with a non-zero wait count
//   stretch the cycle by holding MRDY low. The SPI flash region only decodes
//   while the FT2232 is not driving the flash. The first unmapped access is
//   captured for debug.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_addr         CPU address
//   i_valid        bus cycle strobe, high for the whole access
//   i_FT_CS        FT2232 flash select, active low (low = FT2232 owns flash)
//   i_fault_clr    one-cycle pulse clearing o_unmapped
//   o_ce           registered one-hot (or zero) chip enables
//   o_mrdy         CPU ready, low while the cycle is stretched
//   o_unmapped     sticky unmapped-access flag
//   o_fault_addr   address of the first unmapped access since the last clear
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no cycle in progress, waiting for i_valid
// WAIT   | region selected, MRDY held low while the wait counter runs
// ACTIVE | region selected (or none if unmapped), MRDY high until i_valid drops
module bus_region_decoder #(
  parameter int NUM_REGIONS = 5,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_WIDTH  = 4,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {16'hA002, 16'hA001, 16'hA000, 16'hF000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hF000, 16'hF000},
  parameter logic [NUM_REGIONS*WAIT_WIDTH-1:0] REGION_WAIT =
    {4'd1, 4'd1, 4'd1, 4'd3, 4'd0},
  parameter int FLASH_REGION = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic                   i_valid,
  input  logic                   i_FT_CS,
  input  logic                   i_fault_clr,
  output logic [NUM_REGIONS-1:0] o_ce,
  output logic                   o_mrdy,
  output logic                   o_unmapped,
  output logic [ADDR_WIDTH-1:0]  o_fault_addr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam logic [WAIT_WIDTH-1:0] CNT_ONE = {{(WAIT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [WAIT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0]  ce_q, ce_d;
  logic                    unmapped_q, unmapped_d;
  logic [ADDR_WIDTH-1:0]   fault_addr_q, fault_addr_d;

  logic                    hit_any;
  logic [NUM_REGIONS-1:0]  hit_oh;
  logic [WAIT_WIDTH-1:0]   hit_wait;
  logic [NUM_REGIONS-1:0]  flash_oh;
  logic [NUM_REGIONS-1:0]  ce_gated;

  // Scan from the top down so the lowest matching index overwrites the
  // others and wins on overlap.
  always_comb begin
    hit_any  = 1'b0;
    hit_oh   = '0;
    hit_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (((i_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
           REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          ((i != FLASH_REGION) || i_FT_CS)) begin
        hit_any   = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit_wait  = REGION_WAIT[i*WAIT_WIDTH +: WAIT_WIDTH];
      end
    end
  end

  // Losing flash ownership mid-cycle only kills the flash enable; the cycle
  // itself keeps its timing.
  always_comb begin
    flash_oh               = '0;
    flash_oh[FLASH_REGION] = 1'b1;
    ce_gated               = i_FT_CS ? ce_q : (ce_q & ~flash_oh);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ce_d         = ce_q;
    unmapped_d   = unmapped_q & ~i_fault_clr;
    fault_addr_d = fault_addr_q;

    unique case (state_q)
      S_IDLE: begin
        ce_d  = '0;
        cnt_d = '0;
        if (i_valid) begin
          if (hit_any) begin
            ce_d = hit_oh;
            if (hit_wait != '0) begin
              state_d = S_WAIT;
              cnt_d   = hit_wait;
            end else begin
              state_d = S_ACTIVE;
            end
          end else begin
            state_d    = S_ACTIVE;
            unmapped_d = 1'b1;
            // A clear in the same cycle makes this the first fault again.
            if (!unmapped_q || i_fault_clr) begin
              fault_addr_d = i_addr;
            end
          end
        end
      end

      S_WAIT: begin
        if (!i_valid) begin
          state_d = S_IDLE;
          ce_d    = '0;
          cnt_d   = '0;
        end else begin
          ce_d = ce_gated;
          if (cnt_q == CNT_ONE) begin
            state_d = S_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      S_ACTIVE: begin
        if (!i_valid) begin
          state_d = S_IDLE;
          ce_d    = '0;
        end else begin
          ce_d = ce_gated;
        end
      end

      default: begin
        state_d = S_IDLE;
        ce_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ce_q         <= '0;
      unmapped_q   <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ce_q         <= ce_d;
      unmapped_q   <= unmapped_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign o_ce         = ce_q;
  assign o_mrdy       = (state_q != S_WAIT);
  assign o_unmapped   = unmapped_q;
  assign o_fault_addr = fault_addr_q;

endmodule
